// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: coin credit accumulation, per-item stock,
// one-cycle vend/change pulses. All outputs come straight from flops.
module vending_machine_multi #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES =
        {CREDIT_W'(25), CREDIT_W'(20), CREDIT_W'(15), CREDIT_W'(10)},
    parameter logic [4*CREDIT_W-1:0] COIN_VALS =
        {CREDIT_W'(50), CREDIT_W'(25), CREDIT_W'(10), CREDIT_W'(5)},
    parameter int MAX_CREDIT = 100,
    localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_sel,
    input  logic                 sel_valid,
    input  logic [IW-1:0]        sel_item,
    input  logic                 cancel,
    input  logic                 restock,
    output logic                 vend_valid,
    output logic [IW-1:0]        vend_item,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_amt,
    output logic                 coin_reject,
    output logic                 sel_err,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic [CREDIT_W-1:0]               credit_q, credit_d;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q, stock_d;
    logic                              vend_valid_q, vend_valid_d;
    logic [IW-1:0]                     vend_item_q, vend_item_d;
    logic                              change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]               change_amt_q, change_amt_d;
    logic                              coin_reject_q, coin_reject_d;
    logic                              sel_err_q, sel_err_d;
    logic [NUM_ITEMS-1:0]              sold_out_q, sold_out_d;
    logic                              busy_q, busy_d;

    logic                              sel_hit;
    logic [CREDIT_W-1:0]               sel_price;
    logic [STOCK_W-1:0]                sel_stock;
    logic                              sel_ok;
    logic [CREDIT_W-1:0]               coin_val;
    logic [CREDIT_W:0]                 coin_sum;
    logic                              coin_ok;

    // Item lookup by compare loop so a non-power-of-two NUM_ITEMS never
    // indexes past the price vector or the stock array.
    always_comb begin
        sel_hit   = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (sel_item == IW'(k)) begin
                sel_hit   = 1'b1;
                sel_price = PRICES[k*CREDIT_W +: CREDIT_W];
                sel_stock = stock_q[k];
            end
        end
    end

    always_comb begin
        coin_val = COIN_VALS[coin_sel*CREDIT_W +: CREDIT_W];
        coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
        coin_ok  = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
        sel_ok   = (state_q == CREDIT) && sel_hit && (sel_stock != '0) &&
                   (credit_q >= sel_price);
    end

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_d        = stock_q;
        vend_valid_d   = 1'b0;
        vend_item_d    = '0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        coin_reject_d  = 1'b0;
        sel_err_d      = 1'b0;

        case (state_q)
            IDLE, CREDIT: begin
                if (cancel && (state_q == CREDIT)) begin
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    credit_d       = '0;
                    state_d        = IDLE;
                    coin_reject_d  = coin_valid;
                end else if (sel_valid && sel_ok) begin
                    credit_d      = credit_q - sel_price;
                    vend_valid_d  = 1'b1;
                    vend_item_d   = sel_item;
                    state_d       = VEND;
                    coin_reject_d = coin_valid;
                    for (int k = 0; k < NUM_ITEMS; k++) begin
                        if (sel_item == IW'(k)) begin
                            stock_d[k] = stock_q[k] - STOCK_W'(1);
                        end
                    end
                end else begin
                    // A refused selection does not block a coin in the same cycle.
                    sel_err_d = sel_valid;
                    if (coin_valid) begin
                        if (coin_ok) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                            state_d  = CREDIT;
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    if (restock && (state_q == IDLE)) begin
                        for (int k = 0; k < NUM_ITEMS; k++) begin
                            stock_d[k] = STOCK_W'(INIT_STOCK);
                        end
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                if (credit_q != '0) begin
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    credit_d       = '0;
                    state_d        = CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        for (int k = 0; k < NUM_ITEMS; k++) begin
            sold_out_d[k] = (stock_d[k] == '0);
        end
        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            for (int k = 0; k < NUM_ITEMS; k++) begin
                stock_q[k]    <= STOCK_W'(INIT_STOCK);
                sold_out_q[k] <= (INIT_STOCK == 0);
            end
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_q        <= stock_d;
            sold_out_q     <= sold_out_d;
            vend_valid_q   <= vend_valid_d;
            vend_item_q    <= vend_item_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
            busy_q         <= busy_d;
        end
    end

    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign sel_err      = sel_err_q;
    assign credit       = credit_q;
    assign sold_out     = sold_out_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: one table row per clock plus a
// hand-written reset-during-vend sequence.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       sel_err;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    vending_machine_multi dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_sel(coin_sel),
        .sel_valid(sel_valid), .sel_item(sel_item),
        .cancel(cancel), .restock(restock),
        .vend_valid(vend_valid), .vend_item(vend_item),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .sel_err(sel_err),
        .credit(credit), .sold_out(sold_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       r, cv;
        logic [1:0] cs;
        logic       sv;
        logic [1:0] si;
        logic       cn, rs;
        logic [26:0] exp;
    } vec_t;

    vec_t vq[$];

    // exp packing: vv, vi, cv, ca, coin_rej, sel_err, credit, sold_out, busy
    task automatic add(input string nm, input logic r, cv, input logic [1:0] cs,
                       input logic sv, input logic [1:0] si, input logic cn, rs,
                       input logic evv, input logic [1:0] evi, input logic ecv,
                       input logic [7:0] eca, input logic ecr, ese,
                       input logic [7:0] ecred, input logic [3:0] eso, input logic eb);
        vec_t v;
        v.nm = nm; v.r = r; v.cv = cv; v.cs = cs; v.sv = sv; v.si = si;
        v.cn = cn; v.rs = rs;
        v.exp = {evv, evi, ecv, eca, ecr, ese, ecred, eso, eb};
        vq.push_back(v);
    endtask

    task automatic step(input logic r, cv, input logic [1:0] cs, input logic sv,
                        input logic [1:0] si, input logic cn, rs);
        rst = r; coin_valid = cv; coin_sel = cs; sel_valid = sv;
        sel_item = si; cancel = cn; restock = rs;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] outs();
        return {vend_valid, vend_item, change_valid, change_amt, coin_reject,
                sel_err, credit, sold_out, busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        //   name          r cv cs sv si cn rs | vv vi cv ca  cr se cred so busy
        add("reset",       0,0,0, 0,0, 0,0,   0,0, 0,0,   0,0, 0,  4'h0,0);
        add("coin25",      1,1,2, 0,0, 0,0,   0,0, 0,0,   0,0, 25, 4'h0,0);
        add("coin5",       1,1,0, 0,0, 0,0,   0,0, 0,0,   0,0, 30, 4'h0,0);
        add("buy1",        1,0,0, 1,1, 0,0,   1,1, 0,0,   0,0, 15, 4'h0,1);
        add("change15",    1,0,0, 0,0, 0,0,   0,0, 1,15,  0,0, 0,  4'h0,1);
        add("back_idle",   1,0,0, 0,0, 0,0,   0,0, 0,0,   0,0, 0,  4'h0,0);
        add("coin10",      1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 10, 4'h0,0);
        add("short3",      1,0,0, 1,3, 0,0,   0,0, 0,0,   0,1, 10, 4'h0,0);
        add("cancel10",    1,0,0, 0,0, 1,0,   0,0, 1,10,  0,0, 0,  4'h0,0);
        add("cancel_idle", 1,0,0, 0,0, 1,0,   0,0, 0,0,   0,0, 0,  4'h0,0);
        add("coin50",      1,1,3, 0,0, 0,0,   0,0, 0,0,   0,0, 50, 4'h0,0);
        add("coin25_75",   1,1,2, 0,0, 0,0,   0,0, 0,0,   0,0, 75, 4'h0,0);
        add("over_max",    1,1,3, 0,0, 0,0,   0,0, 0,0,   1,0, 75, 4'h0,0);
        add("at_max",      1,1,2, 0,0, 0,0,   0,0, 0,0,   0,0, 100,4'h0,0);
        add("refund100",   1,0,0, 0,0, 1,0,   0,0, 1,100, 0,0, 0,  4'h0,0);
        add("c10_a",       1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 10, 4'h0,0);
        add("buy0_a",      1,0,0, 1,0, 0,0,   1,0, 0,0,   0,0, 0,  4'h0,1);
        add("end_a",       1,0,0, 0,0, 0,0,   0,0, 0,0,   0,0, 0,  4'h0,0);
        add("c10_b",       1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 10, 4'h0,0);
        add("buy0_b",      1,0,0, 1,0, 0,0,   1,0, 0,0,   0,0, 0,  4'h0,1);
        add("end_b",       1,0,0, 0,0, 0,0,   0,0, 0,0,   0,0, 0,  4'h0,0);
        add("c10_c",       1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 10, 4'h0,0);
        add("buy0_c",      1,0,0, 1,0, 0,0,   1,0, 0,0,   0,0, 0,  4'h1,1);
        add("end_c",       1,0,0, 0,0, 0,0,   0,0, 0,0,   0,0, 0,  4'h1,0);
        add("c10_d",       1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 10, 4'h1,0);
        add("sold_out0",   1,0,0, 1,0, 0,0,   0,0, 0,0,   0,1, 10, 4'h1,0);
        add("restock_crd", 1,0,0, 0,0, 0,1,   0,0, 0,0,   0,0, 10, 4'h1,0);
        add("refund10",    1,0,0, 0,0, 1,0,   0,0, 1,10,  0,0, 0,  4'h1,0);
        add("restock",     1,0,0, 0,0, 0,1,   0,0, 0,0,   0,0, 0,  4'h0,0);
        add("c10_e",       1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 10, 4'h0,0);
        add("c10_f",       1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 20, 4'h0,0);
        add("triple",      1,1,0, 1,0, 1,0,   0,0, 1,20,  1,0, 0,  4'h0,0);
        add("sel_idle",    1,0,0, 1,1, 0,0,   0,0, 0,0,   0,1, 0,  4'h0,0);
        add("c10_g",       1,1,1, 0,0, 0,0,   0,0, 0,0,   0,0, 10, 4'h0,0);
        add("buy_drop",    1,1,0, 1,0, 0,0,   1,0, 0,0,   1,0, 0,  4'h0,1);
        add("coin_vend",   1,1,1, 0,0, 0,0,   0,0, 0,0,   1,0, 0,  4'h0,0);
        add("c25_h",       1,1,2, 0,0, 0,0,   0,0, 0,0,   0,0, 25, 4'h0,0);
        add("buy0_h",      1,0,0, 1,0, 0,0,   1,0, 0,0,   0,0, 15, 4'h0,1);
        add("vend_coin",   1,1,0, 0,0, 1,0,   0,0, 1,15,  1,0, 0,  4'h0,1);
        add("chg_coin",    1,1,0, 1,1, 1,1,   0,0, 0,0,   1,0, 0,  4'h0,0);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].cv, vq[i].cs, vq[i].sv, vq[i].si, vq[i].cn, vq[i].rs);
            chk(vq[i].nm, 32'(outs()), 32'(vq[i].exp));
        end

        // Item0 has one unit left: buy it, then reset in the middle of an item1 vend.
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("last0_sold_out", 32'(sold_out), 32'h1);
        step(1, 1, 2, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        chk("vend1_pulse", 32'({vend_valid, vend_item, busy}), 32'b1011);
        chk("vend1_credit", 32'(credit), 32'd10);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_vend_credit", 32'(credit), 32'd0);
        chk("rst_vend_flags", 32'({busy, change_valid, vend_valid}), 32'd0);
        chk("rst_vend_stock", 32'(sold_out), 32'h0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_nochg", 32'({change_valid, change_amt, busy}), 32'd0);
        chk("post_rst_credit", 32'(credit), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 4: number of products; item index width IW = clog2(NUM_ITEMS), minimum 1.
REQ-002 SHALL have parameter CREDIT_W, default 8: width of every credit, price and change quantity.
REQ-003 SHALL have parameter STOCK_W, default 4: per-item stock counter width.
REQ-004 SHALL have parameter INIT_STOCK, default 3: stock loaded per item at reset and at restock.
REQ-005 SHALL have parameter PRICES, default item0=10, item1=15, item2=20, item3=25: packed NUM_ITEMS*CREDIT_W vector, item k at [k*CREDIT_W +: CREDIT_W].
REQ-006 SHALL have parameter COIN_VALS, default sel0=5, sel1=10, sel2=25, sel3=50: packed 4*CREDIT_W vector of coin values.
REQ-007 SHALL have parameter MAX_CREDIT, default 100: credit ceiling, at most 2^CREDIT_W-1.
REQ-008 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-010 SHALL have port coin_valid, input, 1 bit: a coin is presented this cycle.
REQ-011 SHALL have port coin_sel, input, 2 bits: index into COIN_VALS.
REQ-012 SHALL have port sel_valid, input, 1 bit: product selection request.
REQ-013 SHALL have port sel_item, input, IW bits: requested item index.
REQ-014 SHALL have port cancel, input, 1 bit: refund request.
REQ-015 SHALL have port restock, input, 1 bit: reload all stock counters.
REQ-016 SHALL have port vend_valid / vend_item, outputs, 1 / IW bits: one-cycle dispense pulse and item.
REQ-017 SHALL have port change_valid / change_amt, outputs, 1 / CREDIT_W bits: one-cycle change pulse and amount.
REQ-018 SHALL have port coin_reject / sel_err, outputs, 1 bit each: one-cycle pulses for a refused coin or a refused selection.
REQ-019 SHALL have port credit, output, CREDIT_W bits: current credit.
REQ-020 SHALL have port sold_out, output, NUM_ITEMS bits: bit k high when stock[k]==0.
REQ-021 SHALL have port busy, output, 1 bit: high in VEND and CHANGE.

Function
REQ-022 SHALL implement FSM states IDLE, CREDIT, VEND, CHANGE, with all outputs registered.
REQ-023 SHALL, in IDLE/CREDIT, prioritise requests in the same cycle as cancel > sel_valid > coin_valid; a coin present alongside an accepted higher-priority request is dropped and pulses coin_reject.
REQ-024 SHALL, on an accepted coin, set credit <= credit + COIN_VALS[coin_sel] and move to CREDIT, provided the sum is at most MAX_CREDIT; otherwise credit is unchanged and coin_reject pulses.
REQ-025 SHALL accept a selection in CREDIT only if sel_item < NUM_ITEMS, stock[sel_item] != 0 and credit >= price; else sel_err pulses and state/credit are unchanged.
REQ-026 SHALL, on an accepted selection at edge N, within that edge set credit <= credit - price, decrement stock[sel_item], assert vend_valid with vend_item for exactly one cycle, and move to VEND.
REQ-027 SHALL leave VEND after one cycle, to CHANGE if credit > 0, else to IDLE.
REQ-028 SHALL, on cancel in CREDIT or on entry to CHANGE, pulse change_valid for one cycle with change_amt = credit, set credit <= 0 and return to IDLE; cancel in IDLE is ignored.
REQ-029 SHALL, in VEND/CHANGE, reject coins (coin_reject pulse) and ignore sel_valid, cancel and restock.
REQ-030 SHALL honour restock only in IDLE: every stock[k] <= INIT_STOCK on the next edge.
REQ-031 SHALL hold change_amt and vend_item at 0 whenever their valid is low.
REQ-032 SHALL never underflow stock, and never let credit exceed MAX_CREDIT.

Reset
REQ-033 SHALL, while rst==0 at a rising edge, set state IDLE, credit 0, all pulse outputs 0, vend_item 0, change_amt 0, and every stock to INIT_STOCK, with busy 0 and sold_out reflecting the reloaded stock.
REQ-034 SHALL discard credit mid-transaction on reset without generating change_valid.

Verification
REQ-035 SHALL cover: coin sel2 (25) then sel0 (5), select item1 -> vend_valid item1 one cycle, change_valid amt 15 next cycle, credit 0, IDLE.
REQ-036 SHALL cover: coin 10, select item3 (25) -> sel_err pulse, credit stays 10; cancel -> change_amt 10.
REQ-037 SHALL cover: credit 75, coin sel3 (50) -> coin_reject, credit 75; coin sel2 -> credit 100.
REQ-038 SHALL cover: buy item0 three times with exact 10 -> sold_out[0]=1; fourth select -> sel_err; restock in IDLE -> sold_out[0]=0.
REQ-039 SHALL cover: sel_valid, coin_valid and cancel in the same cycle with credit 20 -> change_amt 20, coin_reject pulse, no vend.
REQ-040 SHALL cover: rst low during VEND -> next cycle credit 0, busy 0, stock INIT_STOCK, no change_valid.
